song_sequencer_ctrl: RTL and testbench



---
 rtl/song_sequencer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_song_sequencer_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer_ctrl.sv
// Autoplay controller: walks a note table in an external ROM, presents each note to the
// tone generator for its programmed beats, inserts an articulation gap, then fetches the next.
module song_sequencer_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int NOTE_W      = 5,
  parameter int DUR_W       = 4,
  parameter int TICK_CYCLES = 250000,
  parameter int GAP_BEATS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic [ADDR_W-1:0]       song_base,
  output logic                    rom_req,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_ack,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_en,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  localparam int TICK_W = (TICK_CYCLES <= 2) ? 1 : $clog2(TICK_CYCLES);
  localparam int GAP_W  = (GAP_BEATS < 2) ? 1 : $clog2(GAP_BEATS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                note_en_q, note_en_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DUR_W-1:0]    beats_q, beats_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [NOTE_W-1:0]   rd_note;
  logic [DUR_W-1:0]    rd_dur;
  logic                tick_wrap;

  assign rd_note   = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rd_dur    = rom_data[DUR_W-1:0];
  assign tick_wrap = (tick_q == TICK_LAST);

  // Handshake: rom_req stays high with rom_addr stable from entry into FETCH until a
  // one-cycle rom_ack is seen; rom_ack in any other state is ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    tick_d  = tick_q;
    beats_d = beats_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      note_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d  = song_base;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_ack) begin
            if (rd_dur == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              note_d  = '0;
            end else begin
              note_d  = rd_note;
              beats_d = rd_dur;
              tick_d  = '0;
              state_d = S_PLAY;
            end
          end
        end
        S_PLAY: begin
          // Pause freezes the count so release resumes with no lost or extra cycles.
          if (!pause) begin
            if (tick_wrap) begin
              tick_d  = '0;
              beats_d = beats_q - DUR_W'(1);
              if (beats_q == DUR_W'(1)) begin
                if (GAP_BEATS == 0) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_FETCH;
                end else begin
                  gap_d   = GAP_INIT;
                  state_d = S_GAP;
                end
              end
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (tick_wrap) begin
              tick_d = '0;
              gap_d  = gap_q - GAP_W'(1);
              if (gap_q == GAP_W'(1)) begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
              end
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Registered outputs are derived from the next state so they align with it.
    req_d     = (state_d == S_FETCH);
    note_en_d = (state_d == S_PLAY) && (note_d != '0) && !pause;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      note_en_q <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
      beats_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      note_en_q <= note_en_d;
      req_q     <= req_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      beats_q   <= beats_d;
      gap_q     <= gap_d;
    end
  end

  assign rom_req   = req_q;
  assign rom_addr  = addr_q;
  assign note      = note_q;
  assign note_en   = note_en_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Directed bench for song_sequencer_ctrl with TICK_CYCLES=4, GAP_BEATS=1 and a ROM model
// that acknowledges two cycles after it first sees rom_req.
module tb_song_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] song_base = 8'd0;
  logic       rom_req;
  logic [7:0] rom_addr;
  logic       rom_ack;
  logic [8:0] rom_data;
  logic [4:0] note;
  logic       note_en;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  song_sequencer_ctrl #(
    .ADDR_W(8), .NOTE_W(5), .DUR_W(4), .TICK_CYCLES(4), .GAP_BEATS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .song_base(song_base), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .note(note), .note_en(note_en),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ROM model: automatic ack two cycles after req, plus a manually injected ack.
  logic [8:0] mem [0:255];
  int         rom_cnt = 0;
  logic       auto_ack = 1'b0;
  logic [8:0] auto_data = 9'd0;
  logic       man_ack = 1'b0;
  logic [8:0] man_data = 9'd0;

  assign rom_ack  = auto_ack | man_ack;
  assign rom_data = man_ack ? man_data : auto_data;

  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (rom_req === 1'b1) begin
      if (rom_cnt == 2) begin
        auto_ack  = 1'b1;
        auto_data = mem[rom_addr];
        rom_cnt   = 0;
      end else begin
        rom_cnt++;
      end
    end else begin
      rom_cnt = 0;
    end
  end

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic [4:0] nt;
    logic       en;
    logic       bsy;
    logic       dn;
  } samp_t;

  samp_t lg [0:127];

  // Cycle 0 is the cycle in which start is presented.
  task automatic begin_song(input logic [7:0] base);
    @(negedge clk);
    song_base = base;
    start     = 1'b1;
  endtask

  // Logs cycles 1..n; event arguments give the cycle an input is asserted (-1 = never).
  task automatic run_log(input int n, input int pf, input int pl, input int sa,
                         input int so, input int ma, input int ra);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      lg[i] = {rom_req, rom_addr, note, note_en, busy, done};
      start = (i == sa);
      if (i == sa) song_base = 8'd99;
      stop    = (i == so);
      rst     = (i == ra);
      pause   = (i >= pf) && (i < pf + pl);
      man_ack = (i == ma);
    end
  endtask

  function automatic int rise_cycle(input int n, input int k);
    int seen = 0;
    for (int i = 1; i <= n; i++) begin
      if (lg[i].req && (i == 1 || !lg[i-1].req)) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int done_cycle(input int n);
    for (int i = 1; i <= n; i++) if (lg[i].dn) return i;
    return -1;
  endfunction

  function automatic int done_count(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (lg[i].dn) c++;
    return c;
  endfunction

  function automatic int en_count(input int lo, input int hi, input logic [4:0] nt);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (lg[i].en && lg[i].nt == nt) c++;
    return c;
  endfunction

  function automatic logic [7:0] addr_at(input int c);
    if (c < 1) return 8'hxx;
    return lg[c].addr;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", rom_req); end
    total++; if (rom_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
    total++; if (note !== 5'd0) begin bad++; $display("FAIL reset_note got=%0d exp=0", note); end
    total++; if (note_en !== 1'b0) begin bad++; $display("FAIL reset_note_en got=%0b exp=0", note_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rom_req !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%0b req=%0b exp=0/0", busy, rom_req); end
  endtask

  task automatic test_song();
    int c;
    mem[5] = {5'd3, 4'd2};
    mem[6] = {5'd7, 4'd1};
    mem[7] = {5'd0, 4'd0};
    begin_song(8'd5);
    run_log(34, -1, 0, -1, -1, -1, -1);
    c = rise_cycle(34, 0);
    total++; if (c != 1 || addr_at(c) !== 8'd5) begin bad++; $display("FAIL song_fetch0 cycle=%0d addr=%0d exp=1/5", c, addr_at(c)); end
    c = rise_cycle(34, 1);
    total++; if (c != 16 || addr_at(c) !== 8'd6) begin bad++; $display("FAIL song_fetch1 cycle=%0d addr=%0d exp=16/6", c, addr_at(c)); end
    c = rise_cycle(34, 2);
    total++; if (c != 27 || addr_at(c) !== 8'd7) begin bad++; $display("FAIL song_fetch2 cycle=%0d addr=%0d exp=27/7", c, addr_at(c)); end
    total++; if (rise_cycle(34, 3) != -1) begin bad++; $display("FAIL song_extra_fetch cycle=%0d exp=-1", rise_cycle(34, 3)); end
    total++; if (en_count(1, 34, 5'd3) != 8 || !lg[4].en) begin bad++; $display("FAIL song_note3_len got=%0d en4=%0b exp=8/1", en_count(1, 34, 5'd3), lg[4].en); end
    total++; if (en_count(12, 15, lg[12].nt) != 0 || !lg[12].bsy || !lg[11].en) begin bad++; $display("FAIL song_gap en=%0d busy=%0b exp=0/1", en_count(12, 15, lg[12].nt), lg[12].bsy); end
    total++; if (en_count(1, 34, 5'd7) != 4 || !lg[19].en) begin bad++; $display("FAIL song_note7_len got=%0d en19=%0b exp=4/1", en_count(1, 34, 5'd7), lg[19].en); end
    total++; if (done_count(34) != 1 || done_cycle(34) != 30) begin bad++; $display("FAIL song_done count=%0d cycle=%0d exp=1/30", done_count(34), done_cycle(34)); end
    total++; if (lg[30].bsy !== 1'b0 || lg[31].bsy !== 1'b0 || lg[30].nt !== 5'd0) begin bad++; $display("FAIL song_end busy=%0b/%0b note=%0d exp=0/0/0", lg[30].bsy, lg[31].bsy, lg[30].nt); end
  endtask

  task automatic test_rest();
    int c;
    int ens = 0;
    int bsy_lo = 0;
    mem[20] = {5'd0, 4'd3};
    mem[21] = {5'd0, 4'd0};
    begin_song(8'd20);
    run_log(26, -1, 0, -1, -1, -1, -1);
    for (int i = 1; i <= 26; i++) if (lg[i].en) ens++;
    for (int i = 1; i <= 22; i++) if (!lg[i].bsy) bsy_lo++;
    total++; if (ens != 0) begin bad++; $display("FAIL rest_note_en got=%0d exp=0", ens); end
    total++; if (bsy_lo != 0) begin bad++; $display("FAIL rest_busy_low got=%0d exp=0", bsy_lo); end
    c = rise_cycle(26, 1);
    total++; if (c != 20 || addr_at(c) !== 8'd21) begin bad++; $display("FAIL rest_next_fetch cycle=%0d addr=%0d exp=20/21", c, addr_at(c)); end
    total++; if (done_cycle(26) != 23) begin bad++; $display("FAIL rest_done cycle=%0d exp=23", done_cycle(26)); end
  endtask

  task automatic test_pause();
    int c;
    int en_lo = 0;
    mem[10] = {5'd3, 4'd2};
    mem[11] = {5'd0, 4'd0};
    begin_song(8'd10);
    run_log(28, 6, 5, -1, -1, -1, -1);
    for (int i = 7; i <= 11; i++) if (!lg[i].en) en_lo++;
    total++; if (en_lo != 5) begin bad++; $display("FAIL pause_muted got=%0d exp=5", en_lo); end
    total++; if (en_count(1, 28, 5'd3) != 8) begin bad++; $display("FAIL pause_en_total got=%0d exp=8", en_count(1, 28, 5'd3)); end
    total++; if (!lg[16].en || lg[17].en) begin bad++; $display("FAIL pause_play_end en16=%0b en17=%0b exp=1/0", lg[16].en, lg[17].en); end
    c = rise_cycle(28, 1);
    total++; if (c != 21 || addr_at(c) !== 8'd11) begin bad++; $display("FAIL pause_next_fetch cycle=%0d addr=%0d exp=21/11", c, addr_at(c)); end
    total++; if (done_cycle(28) != 24) begin bad++; $display("FAIL pause_done cycle=%0d exp=24", done_cycle(28)); end
  endtask

  task automatic test_stop();
    int req_hi = 0;
    mem[30] = {5'd5, 4'd1};
    mem[31] = {5'd0, 4'd0};
    man_data = {5'd5, 4'd1};
    begin_song(8'd30);
    run_log(8, -1, 0, -1, 2, 3, -1);
    for (int i = 3; i <= 8; i++) if (lg[i].req || lg[i].bsy) req_hi++;
    total++; if (lg[2].req !== 1'b1) begin bad++; $display("FAIL stop_pre_req got=%0b exp=1", lg[2].req); end
    total++; if (req_hi != 0) begin bad++; $display("FAIL stop_idle req_or_busy_cycles=%0d exp=0", req_hi); end
    total++; if (lg[4].nt !== 5'd0 || lg[4].en !== 1'b0) begin bad++; $display("FAIL stop_late_ack note=%0d en=%0b exp=0/0", lg[4].nt, lg[4].en); end
    total++; if (done_count(8) != 0) begin bad++; $display("FAIL stop_no_done got=%0d exp=0", done_count(8)); end
    begin_song(8'd30);
    run_log(18, -1, 0, -1, -1, -1, -1);
    total++; if (!lg[4].en || lg[4].nt !== 5'd5) begin bad++; $display("FAIL stop_restart_note en=%0b note=%0d exp=1/5", lg[4].en, lg[4].nt); end
    total++; if (done_cycle(18) != 15) begin bad++; $display("FAIL stop_restart_done cycle=%0d exp=15", done_cycle(18)); end
  endtask

  task automatic test_wrap();
    int c;
    mem[255] = {5'd4, 4'd1};
    mem[0]   = {5'd0, 4'd0};
    begin_song(8'd255);
    run_log(18, -1, 0, -1, -1, -1, -1);
    total++; if (lg[1].addr !== 8'd255 || lg[4].nt !== 5'd4) begin bad++; $display("FAIL wrap_first addr=%0d note=%0d exp=255/4", lg[1].addr, lg[4].nt); end
    c = rise_cycle(18, 1);
    total++; if (c != 12 || addr_at(c) !== 8'd0) begin bad++; $display("FAIL wrap_addr cycle=%0d addr=%0d exp=12/0", c, addr_at(c)); end
    total++; if (done_cycle(18) != 15) begin bad++; $display("FAIL wrap_done cycle=%0d exp=15", done_cycle(18)); end
  endtask

  task automatic test_start_rules();
    int c;
    mem[40] = {5'd6, 4'd2};
    mem[41] = {5'd0, 4'd0};
    begin_song(8'd40);
    run_log(22, -1, 0, 5, -1, -1, -1);
    c = rise_cycle(22, 1);
    total++; if (c != 16 || addr_at(c) !== 8'd41) begin bad++; $display("FAIL busy_start cycle=%0d addr=%0d exp=16/41", c, addr_at(c)); end
    total++; if (done_cycle(22) != 19) begin bad++; $display("FAIL busy_start_done cycle=%0d exp=19", done_cycle(22)); end
    @(negedge clk);
    song_base = 8'd40;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    total++; if (busy !== 1'b0 || rom_req !== 1'b0) begin bad++; $display("FAIL start_stop busy=%0b req=%0b exp=0/0", busy, rom_req); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || rom_req !== 1'b0) begin bad++; $display("FAIL start_stop_hold busy=%0b req=%0b exp=0/0", busy, rom_req); end
  endtask

  task automatic test_rst_mid_play();
    begin_song(8'd40);
    run_log(10, -1, 0, -1, -1, -1, 6);
    total++; if (lg[6].nt !== 5'd6 || !lg[6].en) begin bad++; $display("FAIL rst_pre_play note=%0d en=%0b exp=6/1", lg[6].nt, lg[6].en); end
    total++; if (lg[7].req || lg[7].addr !== 8'd0 || lg[7].nt !== 5'd0 || lg[7].en || lg[7].bsy || lg[7].dn) begin
      bad++; $display("FAIL rst_outputs req=%0b addr=%0d note=%0d en=%0b busy=%0b done=%0b exp=all_0",
                      lg[7].req, lg[7].addr, lg[7].nt, lg[7].en, lg[7].bsy, lg[7].dn);
    end
    total++; if (lg[10].bsy !== 1'b0 || lg[10].req !== 1'b0) begin bad++; $display("FAIL rst_stays_idle busy=%0b req=%0b exp=0/0", lg[10].bsy, lg[10].req); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'd0;
    test_reset();
    test_song();
    test_rest();
    test_pause();
    test_stop();
    test_wrap();
    test_start_rules();
    test_rst_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
